// File: rtl/stp_drv.sv
// Two-phase stepper motor driver: takes move commands (direction, step count, period),
// settles the driver enable, then emits full steps until done, limit, or abort.
module stp_drv #(
  parameter longint CLOCK_HZ      = 24_000_000,
  parameter int     STEP_BITS     = 16,
  parameter int     PERIOD_BITS   = 16,
  parameter int     SETTLE_CYCLES = 64,
  parameter bit     HOLD_TORQUE   = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_dir,
  input  logic [STEP_BITS-1:0]   cmd_steps,
  input  logic [PERIOD_BITS-1:0] cmd_period,
  input  logic                   abort_in,
  input  logic                   limit_sw_near_in,
  input  logic                   limit_sw_far_in,
  output logic                   stp_en_out,
  output logic                   stp_pa_out,
  output logic                   stp_pb_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [1:0]             stop_reason_out,
  output logic [STEP_BITS-1:0]   steps_done_out,
  output logic [1:0]             dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both
  // high; cmd_ready is high only in IDLE, so cmd_valid is a don't-care everywhere else.

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;

  localparam logic [PERIOD_BITS-1:0] MIN_PERIOD  = PERIOD_BITS'(4);
  localparam logic [31:0]            SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  // CLOCK_HZ only documents the clock for benches converting periods to time.
  if (CLOCK_HZ <= 0) begin : g_clock_hz_not_positive
  end

  state_t                 state;
  logic                   dir;
  logic [STEP_BITS-1:0]   steps;
  logic [PERIOD_BITS-1:0] period;
  logic [31:0]            timer;
  logic [1:0]             phase;
  logic                   near_s1, near_s2, far_s1, far_s2;

  logic [PERIOD_BITS-1:0] period_clamped;
  logic [STEP_BITS-1:0]   steps_inc;
  logic [1:0]             phase_next;
  logic                   step_due, settle_end, limit_hit;

  assign period_clamped = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
  assign steps_inc      = steps_done_out + STEP_BITS'(1);
  assign phase_next     = dir ? phase + 2'd1 : phase - 2'd1;
  assign step_due       = (timer == 32'(period) - 32'd1);
  assign settle_end     = (timer == SETTLE_LAST);
  assign limit_hit      = dir ? far_s2 : near_s2;
  assign dbg_state      = state;

  // Gray-coded full-step table: neighbouring indices differ in exactly one coil.
  function automatic logic [1:0] phase_pins(input logic [1:0] p);
    case (p)
      2'd0:    phase_pins = 2'b00;
      2'd1:    phase_pins = 2'b10;
      2'd2:    phase_pins = 2'b11;
      default: phase_pins = 2'b01;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      dir             <= 1'b0;
      steps           <= '0;
      period          <= MIN_PERIOD;
      timer           <= '0;
      phase           <= 2'd0;
      near_s1         <= 1'b0;
      near_s2         <= 1'b0;
      far_s1          <= 1'b0;
      far_s2          <= 1'b0;
      cmd_ready       <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      stop_reason_out <= 2'd0;
      steps_done_out  <= '0;
      stp_en_out      <= 1'b0;
      stp_pa_out      <= 1'b0;
      stp_pb_out      <= 1'b0;
    end else begin
      near_s1  <= limit_sw_near_in;
      near_s2  <= near_s1;
      far_s1   <= limit_sw_far_in;
      far_s2   <= far_s1;
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            dir             <= cmd_dir;
            steps           <= cmd_steps;
            period          <= period_clamped;
            steps_done_out  <= '0;
            stop_reason_out <= 2'd0;
            timer           <= '0;
            cmd_ready       <= 1'b0;
            busy_out        <= 1'b1;
            if (cmd_steps == '0) begin
              state    <= DONE;
              done_out <= 1'b1;
            end else if (stp_en_out || SETTLE_CYCLES == 0) begin
              state      <= RUN;
              stp_en_out <= 1'b1;
            end else begin
              state      <= SETTLE;
              stp_en_out <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (abort_in) begin
            state           <= DONE;
            done_out        <= 1'b1;
            stop_reason_out <= 2'd2;
          end else if (settle_end) begin
            state <= RUN;
            timer <= '0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        RUN: begin
          // Abort beats a limit stop, which beats a normal step on the same cycle.
          if (abort_in) begin
            state           <= DONE;
            done_out        <= 1'b1;
            stop_reason_out <= 2'd2;
          end else if (step_due) begin
            timer <= '0;
            if (limit_hit) begin
              state           <= DONE;
              done_out        <= 1'b1;
              stop_reason_out <= 2'd1;
            end else begin
              phase                    <= phase_next;
              {stp_pa_out, stp_pb_out} <= phase_pins(phase_next);
              steps_done_out           <= steps_inc;
              if (steps_inc == steps) begin
                state           <= DONE;
                done_out        <= 1'b1;
                stop_reason_out <= 2'd0;
              end
            end
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: begin
          state     <= IDLE;
          busy_out  <= 1'b0;
          cmd_ready <= 1'b1;
          if (!HOLD_TORQUE) stp_en_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stp_drv.sv
// Bench for stp_drv: edge-scheduled reference model checked every cycle, directed
// scenarios with literal expectations, a coil-pattern actuator emulator, then random traffic.
module tb_stp_drv;

  localparam int SB = 16;
  localparam int PB = 16;
  localparam int S  = 64;

  logic          clock = 1'b0;
  logic          reset, cmd_valid, cmd_ready, cmd_dir, abort_in;
  logic [SB-1:0] cmd_steps;
  logic [PB-1:0] cmd_period;
  logic          limit_sw_near_in, limit_sw_far_in;
  logic          stp_en_out, stp_pa_out, stp_pb_out, busy_out, done_out;
  logic [1:0]    stop_reason_out, dbg_state;
  logic [SB-1:0] steps_done_out;

  stp_drv #(.CLOCK_HZ(24_000_000), .STEP_BITS(SB), .PERIOD_BITS(PB),
            .SETTLE_CYCLES(S), .HOLD_TORQUE(1'b1)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort_in(abort_in), .limit_sw_near_in(limit_sw_near_in),
    .limit_sw_far_in(limit_sw_far_in), .stp_en_out(stp_en_out),
    .stp_pa_out(stp_pa_out), .stp_pb_out(stp_pb_out), .busy_out(busy_out),
    .done_out(done_out), .stop_reason_out(stop_reason_out),
    .steps_done_out(steps_done_out), .dbg_state(dbg_state));

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int done_cnt = 0;
  int emu_count = 0;
  int emu_bad = 0;
  int chg_q[$];
  logic [1:0] ab_q[$];
  logic [1:0] prev_ab = 2'b00;
  logic [1:0] ab_map[4];
  logic [1:0] cw_seq[8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input longint act, input longint bound);
    checks++;
    if (act > bound) begin
      errors++;
      $display("FAIL %s: got %0d expected at most %0d", name, act, bound);
    end
  endtask

  function automatic int ab_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   ab_idx = 0;
      2'b10:   ab_idx = 1;
      2'b11:   ab_idx = 2;
      default: ab_idx = 3;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Each move is a schedule of step instants (edge numbers); stops are decided at edges.
  int m_ready, m_busy, m_done, m_en, m_reason, m_sd, m_phase;
  int m_dir, m_n, m_per, m_next;
  logic far_p1, far_p2, near_p1, near_p2;

  always @(posedge clock) begin
    logic use_far, use_near;
    edge_n++;
    if (reset) begin
      m_ready = 0; m_busy = 0; m_done = 0; m_en = 0; m_reason = 0; m_sd = 0; m_phase = 0;
      far_p1 = 0; far_p2 = 0; near_p1 = 0; near_p2 = 0;
    end else begin
      use_far  = far_p2;
      use_near = near_p2;
      far_p2   = far_p1;  far_p1  = limit_sw_far_in;
      near_p2  = near_p1; near_p1 = limit_sw_near_in;
      if (m_done == 1) begin
        m_done = 0; m_busy = 0; m_ready = 1;
      end else if (m_busy == 0) begin
        if (m_ready == 1 && cmd_valid) begin
          m_dir = int'(cmd_dir); m_n = int'(cmd_steps);
          m_per = (int'(cmd_period) < 4) ? 4 : int'(cmd_period);
          m_sd = 0; m_reason = 0; m_ready = 0; m_busy = 1;
          if (m_n == 0) m_done = 1;
          else begin
            m_next = edge_n + ((m_en == 1) ? 0 : S) + m_per;
            m_en = 1;
          end
        end else begin
          m_ready = 1;
        end
      end else if (abort_in) begin
        m_reason = 2; m_done = 1;
      end else if (edge_n == m_next) begin
        if ((m_dir == 1) ? use_far : use_near) begin
          m_reason = 1; m_done = 1;
        end else begin
          m_phase = (m_phase + ((m_dir == 1) ? 1 : 3)) % 4;
          m_sd++;
          if (m_sd == m_n) begin m_reason = 0; m_done = 1; end
          else m_next = m_next + m_per;
        end
      end
    end
  end

  // ---------------- per-cycle compare + actuator emulator ----------------
  always @(posedge clock) begin
    logic [1:0] cur_ab;
    int d;
    #1;
    cur_ab = {stp_pa_out, stp_pb_out};
    if (!reset && cur_ab != prev_ab) begin
      d = (ab_idx(cur_ab) - ab_idx(prev_ab) + 4) % 4;
      if (d == 1) emu_count++;
      else if (d == 3) emu_count--;
      else emu_bad++;
      chg_q.push_back(edge_n);
      ab_q.push_back(cur_ab);
    end
    prev_ab = cur_ab;
    if (done_out) done_cnt++;
    checks++;
    if ({cmd_ready, busy_out, done_out, stp_en_out, cur_ab, stop_reason_out, steps_done_out} !==
        {m_ready[0], m_busy[0], m_done[0], m_en[0], ab_map[m_phase], 2'(m_reason), SB'(m_sd)}) begin
      errors++;
      $display("FAIL cycle_cmp edge %0d state %0d: got rdy=%b busy=%b done=%b en=%b ab=%b rsn=%0d sd=%0d expected rdy=%0d busy=%0d done=%0d en=%0d ab=%b rsn=%0d sd=%0d",
               edge_n, dbg_state, cmd_ready, busy_out, done_out, stp_en_out, cur_ab,
               stop_reason_out, steps_done_out, m_ready, m_busy, m_done, m_en,
               ab_map[m_phase], m_reason, m_sd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_move(input logic d, input int n, input int per, output int hs);
    int guard = 0;
    while (!cmd_ready && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = SB'(n);
    cmd_period = PB'(per);
    @(negedge clock);
    hs = edge_n;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int de);
    de = -1;
    for (int i = 0; i < budget; i++) begin
      if (done_out) begin
        de = edge_n;
        break;
      end
      @(negedge clock);
    end
    check("done_seen", (de >= 0) ? 1 : 0, 1);
  endtask

  task automatic wait_changes(input int n, input int budget);
    for (int i = 0; i < budget && chg_q.size() < n; i++) @(negedge clock);
    check("change_count_reached", (chg_q.size() >= n) ? 1 : 0, 1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int hs, de, dc, e0, last, raise_e;
    ab_map = '{2'b00, 2'b10, 2'b11, 2'b01};
    cw_seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; cmd_period = '0;
    abort_in = 1'b0; limit_sw_near_in = 1'b0; limit_sw_far_in = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy_out, 0);
    check("rst_en", stp_en_out, 0);
    check("rst_ab", {stp_pa_out, stp_pb_out}, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_release", cmd_ready, 1);

    // CW 8 steps, period 10, from cold enable: 64 settle cycles then steps every 10
    chg_q.delete(); ab_q.delete();
    do_move(1'b1, 8, 10, hs);
    wait_done(400, de);
    check("cw_edges", chg_q.size(), 8);
    if (chg_q.size() == 8) begin
      check("cw_first_edge_offset", chg_q[0] - hs, 74);
      for (int i = 0; i < 8; i++) check($sformatf("cw_ab_%0d", i), ab_q[i], cw_seq[i]);
      for (int i = 1; i < 8; i++) check($sformatf("cw_gap_%0d", i), chg_q[i] - chg_q[i-1], 10);
    end
    check("cw_steps_done", steps_done_out, 8);
    check("cw_reason", stop_reason_out, 0);

    // period 1 clamps to 4; enable held, so no settle
    chg_q.delete(); ab_q.delete();
    do_move(1'b0, 4, 1, hs);
    wait_done(100, de);
    check("clamp_edges", chg_q.size(), 4);
    if (chg_q.size() == 4) begin
      check("clamp_first_offset", chg_q[0] - hs, 4);
      for (int i = 1; i < 4; i++) check($sformatf("clamp_gap_%0d", i), chg_q[i] - chg_q[i-1], 4);
    end

    // zero steps
    chg_q.delete();
    do_move(1'b1, 0, 7, hs);
    wait_done(10, de);
    check_le("zero_latency", de - hs, 3);
    check("zero_edges", chg_q.size(), 0);
    check("zero_reason", stop_reason_out, 0);

    // far limit during CW move; near limit (opposite side) held and ignored
    chg_q.delete();
    limit_sw_near_in = 1'b1;
    do_move(1'b1, 100, 10, hs);
    wait_changes(5, 200);
    limit_sw_far_in = 1'b1; limit_sw_near_in = 1'b0;
    raise_e = edge_n;
    wait_done(200, de);
    check_le("limit_stop_latency", de - raise_e, 30);
    check("limit_reason", stop_reason_out, 1);
    check("limit_steps_done", steps_done_out, 5);
    @(negedge clock);
    limit_sw_far_in = 1'b0;
    chg_q.delete();
    do_move(1'b0, 6, 5, hs);
    wait_done(100, de);
    check("after_limit_reason", stop_reason_out, 0);
    check("after_limit_steps", steps_done_out, 6);
    check("after_limit_edges", chg_q.size(), 6);

    // abort exactly on a due-step edge
    chg_q.delete();
    do_move(1'b1, 10, 8, hs);
    wait_changes(2, 100);
    last = (chg_q.size() >= 2) ? chg_q[1] : edge_n;
    while (edge_n < last + 7) @(negedge clock);
    abort_in = 1'b1;
    dc = done_cnt;
    @(negedge clock);
    abort_in = 1'b0;
    wait_done(10, de);
    check("abort_done_edge", de - last, 8);
    check("abort_reason", stop_reason_out, 2);
    repeat (3) @(negedge clock);
    check("abort_no_edge", chg_q.size(), 2);
    check("abort_done_pulse_len", done_cnt - dc, 1);

    // abort held in IDLE
    dc = done_cnt;
    abort_in = 1'b1;
    repeat (20) @(negedge clock);
    check("idle_abort_busy", busy_out, 0);
    check("idle_abort_ready", cmd_ready, 1);
    abort_in = 1'b0;
    check("idle_abort_no_done", done_cnt - dc, 0);

    // closed loop with the emulator
    e0 = emu_count;
    do_move(1'b1, 50, 4, hs);
    wait_done(400, de);
    do_move(1'b0, 20, 4, hs);
    wait_done(200, de);
    check("emu_net_steps", emu_count - e0, 30);

    // reset mid-move
    do_move(1'b1, 100, 4, hs);
    repeat (30) @(negedge clock);
    dc = done_cnt;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_ab", {stp_pa_out, stp_pb_out}, 0);
    check("midrst_en", stp_en_out, 0);
    check("midrst_busy", busy_out, 0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_no_done", done_cnt - dc, 0);

    // random traffic against the model
    for (int i = 0; i < 12000; i++) begin
      cmd_valid  = ($urandom_range(0, 5) == 0);
      cmd_dir    = 1'($urandom_range(0, 1));
      cmd_steps  = SB'($urandom_range(0, 10));
      cmd_period = PB'($urandom_range(0, 7));
      abort_in   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) limit_sw_far_in = ~limit_sw_far_in;
      if ($urandom_range(0, 39) == 0) limit_sw_near_in = ~limit_sw_near_in;
      reset      = ($urandom_range(0, 2999) == 0);
      @(negedge clock);
    end
    reset = 1'b0; cmd_valid = 1'b0; abort_in = 1'b0;
    repeat (3) @(negedge clock);
    check("emu_illegal_transitions", emu_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
